// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

  // Sequencer control states.
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_REDIR = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  // Address the PC is cleared to and the reset value of address registers.
  localparam logic [31:0] RESET_VECTOR = '0;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive unacknowledged fetch cycles; expired_o marks the last allowed one.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count: clear wins, increment saturates at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_W'(TIMEOUT - 1));
  end

  // Counter and registered expiry flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the PC register and the instruction-fetch handshake, buffers one
// instruction for decode, applies execute redirects and stops at a halt PC.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    HALT_ADDR = ADDR_W'(32'h0000_004C),
  parameter int unsigned          TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_clk_enable,
  output logic              pc_reset,
  output logic              pc_src,
  output logic [ADDR_W-1:0] pc_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              halted,
  output logic              fetch_error,
  output logic [31:0]       issued_count
);

  fetch_state_t      state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]       count_q, count_d;
  logic              redir_pend_q, redir_pend_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              halted_q, halted_d;
  logic              fetch_error_q, fetch_error_d;
  logic              imem_req_q, imem_req_d;

  logic              to_clear, to_inc, to_expired;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (to_clear),
    .inc_i     (to_inc),
    .expired_o (to_expired)
  );

  // Next-state, register updates and the combinational PC/decode strobes.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    count_d       = count_q;
    redir_pend_d  = redir_pend_q;
    tgt_d         = tgt_q;
    halted_d      = halted_q;
    fetch_error_d = fetch_error_q;
    pc_clk_enable = 1'b0;
    pc_reset      = 1'b0;
    pc_src        = 1'b0;
    pc_target     = '0;
    instr_valid   = 1'b0;
    to_clear      = 1'b1;
    to_inc        = 1'b0;

    unique case (state_q)
      S_INIT: begin
        pc_reset      = 1'b1;
        pc_clk_enable = 1'b1;
        state_d       = S_FETCH;
      end
      S_FETCH: begin
        to_clear = imem_ack;
        to_inc   = !imem_ack;
        // Newest redirect wins while the fetch is outstanding.
        if (redirect_valid) begin
          redir_pend_d = 1'b1;
          tgt_d        = redirect_target;
        end
        if (imem_ack) begin
          if (redir_pend_q || redirect_valid) begin
            state_d = S_REDIR;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            state_d    = S_ISSUE;
          end
        end else if (to_expired) begin
          fetch_error_d = 1'b1;
          halted_d      = 1'b1;
          state_d       = S_HALT;
        end
      end
      S_ISSUE: begin
        instr_valid = !stall && !redirect_valid;
        // A redirect squashes the buffered instruction even under stall.
        if (redirect_valid) begin
          pc_clk_enable = 1'b1;
          pc_src        = 1'b1;
          pc_target     = redirect_target;
          state_d       = S_FETCH;
        end else if (instr_valid && instr_ready) begin
          count_d = count_q + 32'd1;
          if (instr_pc_q == HALT_ADDR) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_clk_enable = 1'b1;
            state_d       = S_FETCH;
          end
        end
      end
      S_REDIR: begin
        pc_clk_enable = 1'b1;
        pc_src        = 1'b1;
        pc_target     = redirect_valid ? redirect_target : tgt_q;
        redir_pend_d  = 1'b0;
        state_d       = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    imem_req_d = (state_d == S_FETCH);
  end

  // State, instruction buffer, counters and sticky status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      instr_q       <= '0;
      instr_pc_q    <= ADDR_W'(RESET_VECTOR);
      count_q       <= '0;
      redir_pend_q  <= 1'b0;
      tgt_q         <= ADDR_W'(RESET_VECTOR);
      halted_q      <= 1'b0;
      fetch_error_q <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      count_q       <= count_d;
      redir_pend_q  <= redir_pend_d;
      tgt_q         <= tgt_d;
      halted_q      <= halted_d;
      fetch_error_q <= fetch_error_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_addr    = (state_q == S_FETCH) ? pc : '0;
  assign imem_req     = imem_req_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign halted       = halted_q;
  assign fetch_error  = fetch_error_q;
  assign issued_count = count_q;

endmodule
